// File: rtl/rr_grant_pkg.sv
// rtl/rr_grant_pkg.sv - shared constants and state type for the round-robin grant encoder
package rr_grant_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority winner search over four requesters
module rr_pick
    import rr_grant_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] win
);

    logic [IDX_W-1:0] cand;

    // Scan from last+1 upward with natural 2-bit wrap; last itself is checked last
    always_comb begin
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// rtl/rr_grant_encoder.sv - round-robin arbiter producing registered grant index, valid and timeout pulse
module rr_grant_encoder
    import rr_grant_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [IDX_W-1:0] pick_win;

    rr_pick u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .win  (pick_win)
    );

    // Arbitration FSM: grant from IDLE, hold until done / request drop / hold limit,
    // then always pass through one IDLE cycle so the decoder never sees a live select change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
            last    <= IDX_W'(N_REQ - 1);
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx <= pick_win;
                        gnt_vld <= 1'b1;
                        last    <= pick_win;
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Voluntary release wins over expiry so a coincident done is not flagged
                    if (done || !req[gnt_idx]) begin
                        gnt_vld <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        gnt_vld <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt_vld <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
